// File: rtl/shift_seq.sv
// Multi-cycle N-position shift sequencer driving an external single-bit shifter (SA/SLA/SLR -> SY/SC).
// Define SHIFT_SEQ_STICKY_EN to add the sticky output S (OR of every bit shifted out).
module shift_seq #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  A,
  input  logic [AW-1:0] AMT,
  input  logic          LA,
  input  logic          LR,
  output logic [W-1:0]  SA,
  output logic          SLA,
  output logic          SLR,
  input  logic [W-1:0]  SY,
  input  logic          SC,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  Y,
  output logic          C,
  output logic          Z
`ifdef SHIFT_SEQ_STICKY_EN
  ,
  output logic          S
`endif
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  work_q, work_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          la_q, la_d;
  logic          lr_q, lr_d;
  logic          c_q, c_d;
  logic          done_q, done_d;
`ifdef SHIFT_SEQ_STICKY_EN
  logic          s_q, s_d;
`endif

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    la_d    = la_q;
    lr_d    = lr_q;
    c_d     = c_q;
    done_d  = 1'b0;
`ifdef SHIFT_SEQ_STICKY_EN
    s_d     = s_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          work_d  = A;
          cnt_d   = AMT;
          la_d    = LA;
          lr_d    = LR;
          c_d     = 1'b0;
`ifdef SHIFT_SEQ_STICKY_EN
          s_d     = 1'b0;
`endif
        end
      end
      SHIFT: begin
        // Gating the decrement on a nonzero count keeps cnt from ever wrapping.
        if (cnt_q != '0) begin
          work_d = SY;
          c_d    = SC;
          cnt_d  = cnt_q - {{(AW-1){1'b0}}, 1'b1};
`ifdef SHIFT_SEQ_STICKY_EN
          s_d    = s_q | SC;
`endif
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      la_q    <= 1'b0;
      lr_q    <= 1'b0;
      c_q     <= 1'b0;
      done_q  <= 1'b0;
`ifdef SHIFT_SEQ_STICKY_EN
      s_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      la_q    <= la_d;
      lr_q    <= lr_d;
      c_q     <= c_d;
      done_q  <= done_d;
`ifdef SHIFT_SEQ_STICKY_EN
      s_q     <= s_d;
`endif
    end
  end

  // The shifter sees the working register directly, so its inputs are stable for a whole cycle.
  assign SA   = work_q;
  assign SLA  = la_q;
  assign SLR  = lr_q;
  assign Y    = work_q;
  assign C    = c_q;
  assign Z    = (work_q == '0);
  assign busy = (state_q == SHIFT);
  assign done = done_q;
`ifdef SHIFT_SEQ_STICKY_EN
  assign S    = s_q;
`endif

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq: a behavioural single-bit shifter closes the loop,
// and closed-form expected results are queued at each start and popped at done.
module tb_shift_seq;

  localparam int W  = 8;
  localparam int AW = 4;

  typedef struct {
    logic [W-1:0] y;
    logic         c;
    logic         s;
    int           amt;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          start;
  logic [W-1:0]  a;
  logic [AW-1:0] amt;
  logic          la;
  logic          lr;
  logic [W-1:0]  sa;
  logic          sla;
  logic          slr;
  logic [W-1:0]  sy;
  logic          sc;
  logic          busy;
  logic          done;
  logic [W-1:0]  y;
  logic          c;
  logic          z;
`ifdef SHIFT_SEQ_STICKY_EN
  logic          s;
`endif

  exp_t sb[$];
  int   n_cmp;
  int   n_err;

  shift_seq #(.W(W), .AW(AW)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .A(a),
    .AMT(amt),
    .LA(la),
    .LR(lr),
    .SA(sa),
    .SLA(sla),
    .SLR(slr),
    .SY(sy),
    .SC(sc),
    .busy(busy),
    .done(done),
    .Y(y),
    .C(c),
    .Z(z)
`ifdef SHIFT_SEQ_STICKY_EN
    ,
    .S(s)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-bit shifter: left fills 0, right fills 0 (logical) or the sign bit (arithmetic).
  always_comb begin
    if (!slr) begin
      sy = {sa[W-2:0], 1'b0};
      sc = sa[W-1];
    end else begin
      sy = {(sla ? 1'b0 : sa[W-1]), sa[W-1:1]};
      sc = sa[0];
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1);
  end

  // Closed-form N-position shift result, independent of any iteration.
  function automatic exp_t ref_model(input logic [W-1:0] av, input int n, input logic lav, input logic lrv);
    exp_t               e;
    logic signed [W-1:0] sv;
    e.amt = n;
    e.s   = 1'b0;
    sv    = av;
    if (!lrv) begin
      e.y = (n >= W) ? '0 : (av << n);
      e.c = (n == 0 || n > W) ? 1'b0 : av[W-n];
      for (int i = 0; i < W; i++) if (i + n >= W) e.s = e.s | av[i];
    end else begin
      if (lav) e.y = (n >= W) ? '0 : (av >> n);
      else     e.y = sv >>> n;
      if (n == 0)      e.c = 1'b0;
      else if (n <= W) e.c = av[n-1];
      else             e.c = lav ? 1'b0 : av[W-1];
      for (int i = 0; i < W; i++) if (i < n) e.s = e.s | av[i];
    end
    return e;
  endfunction

  // Called at a negedge; drives one start pulse and returns at the following negedge.
  task automatic issue(input logic [W-1:0] av, input int n, input logic lav, input logic lrv);
    a     = av;
    amt   = n[AW-1:0];
    la    = lav;
    lr    = lrv;
    start = 1'b1;
    sb.push_back(ref_model(av, n, lav, lrv));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int first, output int cycles, output int busy_n);
    cycles = first;
    busy_n = 0;
    while (done !== 1'b1 && cycles < 60) begin
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
      cycles++;
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL done_timeout: done=%b, required 1 within 60 cycles", done);
    end
  endtask

  task automatic test_reset();
    int saw_done;
    reset = 1'b1;
    start = 1'b0;
    a = '0; amt = '0; la = 1'b0; lr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    saw_done = 0;
    repeat (5) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1;
    end
    n_cmp++; if (saw_done != 0) begin n_err++; $display("[TB] FAIL reset_done: done pulsed while idle, required never"); end
    n_cmp++; if (y !== 8'h00) begin n_err++; $display("[TB] FAIL reset_y: got %h required 00", y); end
    n_cmp++; if (c !== 1'b0) begin n_err++; $display("[TB] FAIL reset_c: got %b required 0", c); end
    n_cmp++; if (z !== 1'b1) begin n_err++; $display("[TB] FAIL reset_z: got %b required 1", z); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
`ifdef SHIFT_SEQ_STICKY_EN
    n_cmp++; if (s !== 1'b0) begin n_err++; $display("[TB] FAIL reset_s: got %b required 0", s); end
`endif
  endtask

  task automatic test_left();
    exp_t e;
    int   cyc, bn;
    issue(8'h96, 3, 1'b0, 1'b0);
    wait_done(1, cyc, bn);
    e = sb.pop_front();
    n_cmp++; if (cyc != e.amt + 2) begin n_err++; $display("[TB] FAIL left_latency: got %0d required %0d", cyc, e.amt + 2); end
    n_cmp++; if (bn != e.amt + 1) begin n_err++; $display("[TB] FAIL left_busy_cycles: got %0d required %0d", bn, e.amt + 1); end
    n_cmp++; if (y !== e.y) begin n_err++; $display("[TB] FAIL left_y: got %h required %h", y, e.y); end
    n_cmp++; if (c !== e.c) begin n_err++; $display("[TB] FAIL left_c: got %b required %b", c, e.c); end
    n_cmp++; if (z !== (e.y == 0)) begin n_err++; $display("[TB] FAIL left_z: got %b required %b", z, (e.y == 0)); end
`ifdef SHIFT_SEQ_STICKY_EN
    n_cmp++; if (s !== e.s) begin n_err++; $display("[TB] FAIL left_s: got %b required %b", s, e.s); end
`endif
    // done must be a single-cycle pulse and the result must hold while idle.
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("[TB] FAIL left_done_pulse: got %b required 0", done); end
    n_cmp++; if (y !== e.y) begin n_err++; $display("[TB] FAIL left_hold_y: got %h required %h", y, e.y); end
  endtask

  task automatic test_right();
    exp_t e;
    int   cyc, bn;
    for (int k = 0; k < 2; k++) begin
      issue(8'h96, 2, (k == 1), 1'b1);
      wait_done(1, cyc, bn);
      e = sb.pop_front();
      n_cmp++; if (cyc != e.amt + 2) begin n_err++; $display("[TB] FAIL right%0d_latency: got %0d required %0d", k, cyc, e.amt + 2); end
      n_cmp++; if (y !== e.y) begin n_err++; $display("[TB] FAIL right%0d_y: got %h required %h", k, y, e.y); end
      n_cmp++; if (c !== e.c) begin n_err++; $display("[TB] FAIL right%0d_c: got %b required %b", k, c, e.c); end
      @(negedge clk);
    end
  endtask

  task automatic test_amounts();
    exp_t       e;
    int         cyc, bn;
    logic [W-1:0] av [4] = '{8'h5A, 8'h80, 8'h80, 8'hB3};
    int         nv [4] = '{0, 9, 12, 15};
    logic       lav [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic       lrv [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 4; k++) begin
      issue(av[k], nv[k], lav[k], lrv[k]);
      wait_done(1, cyc, bn);
      e = sb.pop_front();
      n_cmp++; if (cyc != e.amt + 2) begin n_err++; $display("[TB] FAIL amt%0d_latency: got %0d required %0d", k, cyc, e.amt + 2); end
      n_cmp++; if (bn != e.amt + 1) begin n_err++; $display("[TB] FAIL amt%0d_busy_cycles: got %0d required %0d", k, bn, e.amt + 1); end
      n_cmp++; if (y !== e.y) begin n_err++; $display("[TB] FAIL amt%0d_y: got %h required %h", k, y, e.y); end
      n_cmp++; if (c !== e.c) begin n_err++; $display("[TB] FAIL amt%0d_c: got %b required %b", k, c, e.c); end
      n_cmp++; if (z !== (e.y == 0)) begin n_err++; $display("[TB] FAIL amt%0d_z: got %b required %b", k, z, (e.y == 0)); end
`ifdef SHIFT_SEQ_STICKY_EN
      n_cmp++; if (s !== e.s) begin n_err++; $display("[TB] FAIL amt%0d_s: got %b required %b", k, s, e.s); end
`endif
      @(negedge clk);
    end
  endtask

  task automatic test_ignored_start();
    exp_t e;
    int   cyc, bn;
    issue(8'h96, 5, 1'b0, 1'b0);
    @(negedge clk);
    a     = 8'hFF;
    amt   = 4'd1;
    la    = 1'b1;
    lr    = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    amt   = 4'd9;
    wait_done(3, cyc, bn);
    e = sb.pop_front();
    n_cmp++; if (cyc != e.amt + 2) begin n_err++; $display("[TB] FAIL ignore_latency: got %0d required %0d", cyc, e.amt + 2); end
    n_cmp++; if (y !== e.y) begin n_err++; $display("[TB] FAIL ignore_y: got %h required %h", y, e.y); end
    n_cmp++; if (c !== e.c) begin n_err++; $display("[TB] FAIL ignore_c: got %b required %b", c, e.c); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL ignore_no_queue: busy=%b required 0", busy); end
  endtask

  task automatic test_back_to_back();
    exp_t       e;
    int         cyc, bn;
    logic [W-1:0] av [3] = '{8'h5A, 8'h81, 8'h0F};
    int         nv [3] = '{1, 4, 6};
    logic       lav [3] = '{1'b0, 1'b0, 1'b1};
    logic       lrv [3] = '{1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 3; k++) begin
      // From the second operation on, start is raised while done is still high.
      issue(av[k], nv[k], lav[k], lrv[k]);
      wait_done(1, cyc, bn);
      e = sb.pop_front();
      n_cmp++; if (cyc != e.amt + 2) begin n_err++; $display("[TB] FAIL b2b%0d_latency: got %0d required %0d", k, cyc, e.amt + 2); end
      n_cmp++; if (y !== e.y) begin n_err++; $display("[TB] FAIL b2b%0d_y: got %h required %h", k, y, e.y); end
      n_cmp++; if (c !== e.c) begin n_err++; $display("[TB] FAIL b2b%0d_c: got %b required %b", k, c, e.c); end
`ifdef SHIFT_SEQ_STICKY_EN
      n_cmp++; if (s !== e.s) begin n_err++; $display("[TB] FAIL b2b%0d_s: got %b required %b", k, s, e.s); end
`endif
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    exp_t e;
    int   cyc, bn, saw_done;
    issue(8'h96, 7, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    void'(sb.pop_back());
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL abort_busy: got %b required 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("[TB] FAIL abort_done: got %b required 0", done); end
    n_cmp++; if (y !== 8'h00) begin n_err++; $display("[TB] FAIL abort_y: got %h required 00", y); end
    n_cmp++; if (c !== 1'b0) begin n_err++; $display("[TB] FAIL abort_c: got %b required 0", c); end
    n_cmp++; if (z !== 1'b1) begin n_err++; $display("[TB] FAIL abort_z: got %b required 1", z); end
    saw_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1;
    end
    n_cmp++; if (saw_done != 0) begin n_err++; $display("[TB] FAIL abort_no_done: done pulsed after abort, required never"); end
    issue(8'h3C, 2, 1'b1, 1'b1);
    wait_done(1, cyc, bn);
    e = sb.pop_front();
    n_cmp++; if (cyc != e.amt + 2) begin n_err++; $display("[TB] FAIL post_abort_latency: got %0d required %0d", cyc, e.amt + 2); end
    n_cmp++; if (y !== e.y) begin n_err++; $display("[TB] FAIL post_abort_y: got %h required %h", y, e.y); end
    n_cmp++; if (c !== e.c) begin n_err++; $display("[TB] FAIL post_abort_c: got %b required %b", c, e.c); end
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    amt   = '0;
    la    = 1'b0;
    lr    = 1'b0;
    @(negedge clk);
    test_reset();
    test_left();
    test_right();
    test_amounts();
    test_ignored_start();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shift_seq.md
Name: shift_seq

Overview:
- Multi-cycle sequencer that performs an N-position shift using the single-bit combinational shifter (8-bit, LA/LR controls, Y/C outputs).
- The shifter sits directly downstream of this block's working register, and its output feeds back into that register.
- Takes an operand and a shift amount, then iterates one shifter pass per clock.
- Returns the final value, the last bit shifted out, and a zero flag, using a start/busy/done handshake.

Parameters:
- W, 8, data width; must equal the width of the attached single-bit shifter.
- AW, 4, shift-amount width; legal amounts are 0 to 2^AW-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; accepted only in IDLE.
- A  input  W  operand; sampled when start is accepted.
- AMT  input  AW  shift count; sampled when start is accepted.
- LA  input  1  shift mode for right shifts: 1 = logical, 0 = arithmetic; sampled with start.
- LR  input  1  direction: 0 = left, 1 = right; sampled with start.
- SA  output  W  operand driven to the shifter; equals the working register.
- SLA  output  1  latched LA driven to the shifter.
- SLR  output  1  latched LR driven to the shifter.
- SY  input  W  shifter result.
- SC  input  1  shifter carry-out.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when the result is valid.
- Y  output  W  result; equals the working register.
- C  output  1  last bit shifted out; 0 if AMT = 0.
- Z  output  1  high when Y == 0; combinational from Y.

Behaviour:
- Reset (synchronous, active-high, overrides everything):
  - state = IDLE; working register = 0; count = 0; latched LA = latched LR = 0.
  - C = 0, busy = 0, done = 0, so Y = 0 and Z = 1.
- States: IDLE, SHIFT.
- IDLE:
  - On an edge with start = 1: work <= A, cnt <= AMT, latch LA and LR, C <= 0, go to SHIFT.
  - start = 0: hold all outputs. The result stays on Y/C/Z until the next accepted start.
- SHIFT:
  - busy = 1.
  - On each edge with cnt != 0: work <= SY, C <= SC, cnt <= cnt-1.
  - On the edge with cnt == 0: go to IDLE, done <= 1 for exactly one cycle; work and C are unchanged.
- Latency: done is high during the cycle beginning AMT+1 edges after the accepting edge. AMT = 0 gives done one cycle after start, with Y = A and C = 0.
- start while in SHIFT is ignored, with no queuing. start in the same cycle that done is high is accepted, because the state is already IDLE.
- A, AMT, LA and LR changing during SHIFT have no effect.
- SA, SLA and SLR are driven continuously from registers, so the shifter sees stable inputs for a full cycle.
- Large amounts (AMT >= W) iterate normally:
  - left and logical-right shifts yield 0;
  - arithmetic right yields all bits equal to the sign bit.
- Reset asserted during SHIFT aborts the operation: next cycle is IDLE with the reset values, and done is not pulsed.
- No arithmetic beyond the cnt decrement; cnt never wraps because the decrement is gated by cnt != 0.

Optional Feature:
- Macro SHIFT_SEQ_STICKY_EN.
- Defined:
  - adds output port S (1 bit), the sticky bit;
  - S <= 0 on reset and on an accepted start;
  - S <= S | SC on each shifting edge, i.e. the OR of all bits shifted out (for rounding).
- Not defined: port S is absent, and there is no sticky logic or register.

Test Plan:
- Reset, then idle with no start -> Y = 0x00, C = 0, Z = 1, busy = 0, done never asserted.
- A = 0x96, AMT = 3, LR = 0 (left), pulse start -> busy for 4 cycles, then done pulse; Y = 0xB0, C = 0, Z = 0; S = 1 if the sticky feature is enabled.
- A = 0x96, AMT = 2, LR = 1, LA = 0 (arithmetic right) -> Y = 0xE5, C = 1. Repeat with LA = 1 (logical right) -> Y = 0x25, C = 1.
- A = 0x5A, AMT = 0 -> done one cycle after start; Y = 0x5A, C = 0. Then A = 0x80, AMT = 9, left -> Y = 0x00, Z = 1, done after 10 cycles.
- Start A = 0x96, AMT = 5; pulse start again with A = 0xFF two cycles later -> second start ignored; the result matches the first operation. A start issued in the done cycle is accepted.
- Start A = 0x96, AMT = 7; assert reset during the third SHIFT cycle -> IDLE next cycle, Y = 0, C = 0, no done pulse. A subsequent start operates normally.
